rect_drawer: RTL
================

Name: rect_drawer

Overview:
Parametrised successor to the fixed 4x4 square plotter. It draws a filled or outlined rectangle of run-time width and height at a latched origin. Output is one pixel per clock in raster order, straight into the vga_adapter x/y/colour/plot inputs. It adds a go/busy/done handshake, an outline mode and screen-edge clipping, so game-object drawing and erase FSMs can sequence it.

Parameters:
X_W, 8, x coordinate width (160-wide screen)
Y_W, 7, y coordinate width (120-high screen)
COL_W, 3, colour width
SZ_W, 5, width/height field width (max 31x31 rectangle)
SCREEN_W, 160, pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  synchronous active-low reset
go  in  1  start request, sampled only in IDLE
x0  in  X_W  rectangle origin x (top-left)
y0  in  Y_W  rectangle origin y
w  in  SZ_W  rectangle width in pixels
h  in  SZ_W  rectangle height in pixels
colour_in  in  COL_W  draw colour
outline  in  1  0 = filled, 1 = 1-pixel border only
x  out  X_W  pixel x to VGA adapter
y  out  Y_W  pixel y to VGA adapter
colour  out  COL_W  pixel colour
plot  out  1  write enable for the current pixel
busy  out  1  high while a draw is in progress, including the DONE cycle
done  out  1  one-cycle pulse at end of draw

Behaviour:
- Reset is synchronous and active-low on clk. Reset forces: state IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, counters=0, latched operands=0.
- States: IDLE, DRAW, DONE.
- IDLE with go=1 at a clock edge:
  - Latch x0, y0, w, h, colour_in and outline.
  - If w==0 or h==0, go to DONE; nothing is plotted.
  - Otherwise go to DRAW with xcnt=0 and ycnt=0.
- IDLE with go=0: stay in IDLE.
- DRAW scans one pixel per cycle:
  - Every DRAW cycle presents x = x0_l+xcnt, y = y0_l+ycnt and colour = colour_l.
  - xcnt increments each cycle. At xcnt==w_l-1, xcnt wraps to 0 and ycnt increments.
  - At xcnt==w_l-1 and ycnt==h_l-1, go to DONE.
- Latency: a go sampled at edge N gives the first pixel in cycle N+1 and the last pixel in cycle N+w*h. done=1 in cycle N+w*h+1, then IDLE. The outline flag does not change latency.
- plot=1 in DRAW only if both of these hold:
  - (a) the pixel is on screen. Sums are computed one bit wider (X_W+1, Y_W+1) and the pixel must satisfy x_sum < SCREEN_W and y_sum < SCREEN_H.
  - (b) outline==0, or the pixel is on the border: xcnt==0, xcnt==w_l-1, ycnt==0 or ycnt==h_l-1.
- Clipped or interior pixels still use one cycle with plot=0, so timing stays deterministic. x and y outputs are the low X_W/Y_W bits of the sums.
- plot=0 in IDLE and DONE.
- done: exactly one cycle, in DONE only.
- busy=1 in DRAW and DONE, and 0 in IDLE. go is ignored while busy.
- go held high continuously: the next draw starts from IDLE in the cycle after DONE, which gives back-to-back draws with a 1-cycle gap.
- Input changes during DRAW have no effect; only latched operands are used.
- Reset mid-draw: the next edge with resetn=0 returns everything to reset values. No further plot pulses occur and there is no done.
- A 1x1 rectangle plots exactly one pixel, in both modes.

Decomposition:
- Package rect_drawer_pkg holds:
  - the state encoding constants (IDLE, DRAW, DONE);
  - the mode constants (MODE_FILL=0, MODE_OUTLINE=1);
  - the default screen dimensions 160/120.
- One sub-module, scan_counter_2d. It is parametrised by SZ_W and has inputs clk, resetn, clear, enable, w and h, and outputs xcnt, ycnt, last and on_border. The top level keeps the FSM, operand latches, adders and clip logic.

Test Plan:
- Fill 4x4 at (10,20), colour 3'b100, go at cycle 0 -> 16 plot pulses in cycles 1..16 in raster order (10,20),(11,20)...(13,23); done in cycle 17; busy high cycles 1..17.
- Outline 5x3 at (0,0) -> 15 DRAW cycles; plot high for 12 border pixels and low for the interior (1..3,1); done in cycle 16.
- Clip: fill 4x2 at (158,118) -> plots only (158,118),(159,118),(158,119),(159,119); remaining 4 cycles plot=0; done in cycle 9.
- w=0, h=7 -> no plot pulses; done=1 in cycle 1; back in IDLE in cycle 2.
- go held high with operands changed mid-draw for a 2x2 -> first draw uses the latched operands; second draw starts the cycle after done; the second draw's 4 pixels use the operands present at its own go sample.
- resetn=0 at cycle 5 of a 4x4 draw -> from cycle 6: plot=0, busy=0, x=y=0, and done never asserts.

Source files
------------

// File: rtl/rect_drawer_pkg.sv
// Shared constants for the rectangle drawer: FSM state encoding,
// fill/outline mode values and default screen dimensions.
package rect_drawer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

endpackage

// File: rtl/scan_counter_2d.sv
// Raster-order 2D scan counter over a w x h window.
// Ports: clk, resetn (sync, active-low), clear, enable, w, h in;
//        xcnt, ycnt, last (final pixel), on_border (edge pixel) out.
module scan_counter_2d #(
    parameter int SZ_W = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            enable,
    input  logic [SZ_W-1:0] w,
    input  logic [SZ_W-1:0] h,
    output logic [SZ_W-1:0] xcnt,
    output logic [SZ_W-1:0] ycnt,
    output logic            last,
    output logic            on_border
);

    logic [SZ_W-1:0] x_max;
    logic [SZ_W-1:0] y_max;
    logic            row_end;

    // Only meaningful for w,h > 0; the caller never scans an empty window.
    assign x_max     = w - SZ_W'(1);
    assign y_max     = h - SZ_W'(1);
    assign row_end   = (xcnt == x_max);
    assign last      = row_end && (ycnt == y_max);
    assign on_border = (xcnt == '0) || row_end ||
                       (ycnt == '0) || (ycnt == y_max);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            xcnt <= '0;
            ycnt <= '0;
        end else if (enable) begin
            if (row_end) begin
                xcnt <= '0;
                ycnt <= ycnt + SZ_W'(1);
            end else begin
                xcnt <= xcnt + SZ_W'(1);
            end
        end
    end

endmodule

// File: rtl/rect_drawer.sv
// Filled/outlined rectangle plotter, one pixel per clock, with clipping.
// Ports: clk, resetn, go, x0, y0, w, h, colour_in, outline in;
//        x, y, colour, plot (VGA adapter), busy, done out.
module rect_drawer
    import rect_drawer_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int SZ_W     = 5,
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [SZ_W-1:0]  w,
    input  logic [SZ_W-1:0]  h,
    input  logic [COL_W-1:0] colour_in,
    input  logic             outline,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_nx;

    logic [X_W-1:0]   x0_l;
    logic [Y_W-1:0]   y0_l;
    logic [SZ_W-1:0]  w_l;
    logic [SZ_W-1:0]  h_l;
    logic [COL_W-1:0] colour_l;
    logic             outline_l;

    logic [SZ_W-1:0]  xcnt;
    logic [SZ_W-1:0]  ycnt;
    logic             last;
    logic             on_border;

    // One extra bit so origins near the edge cannot wrap back on screen.
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;
    logic             on_screen;
    logic             mode_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            x0_l      <= '0;
            y0_l      <= '0;
            w_l       <= '0;
            h_l       <= '0;
            colour_l  <= '0;
            outline_l <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && go) begin
                x0_l      <= x0;
                y0_l      <= y0;
                w_l       <= w;
                h_l       <= h;
                colour_l  <= colour_in;
                outline_l <= outline;
            end
        end
    end

    // Counter is held at zero outside DRAW, so entry always starts at (0,0).
    scan_counter_2d #(
        .SZ_W(SZ_W)
    ) u_scan (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (state != DRAW),
        .enable   (state == DRAW),
        .w        (w_l),
        .h        (h_l),
        .xcnt     (xcnt),
        .ycnt     (ycnt),
        .last     (last),
        .on_border(on_border)
    );

    assign x_sum     = {1'b0, x0_l} + (X_W+1)'(xcnt);
    assign y_sum     = {1'b0, y0_l} + (Y_W+1)'(ycnt);
    assign on_screen = (x_sum < (X_W+1)'(SCREEN_W)) &&
                       (y_sum < (Y_W+1)'(SCREEN_H));
    assign mode_ok   = (outline_l == MODE_FILL) ||
                       ((outline_l == MODE_OUTLINE) && on_border);

    always_comb begin
        state_nx = state;
        x        = '0;
        y        = '0;
        colour   = '0;
        plot     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx = (w == '0 || h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                busy   = 1'b1;
                x      = x_sum[X_W-1:0];
                y      = y_sum[Y_W-1:0];
                colour = colour_l;
                plot   = on_screen && mode_ok;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
